// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Package : lcd_pkg
// Desc    : Shared HD44780 instruction classes, bit positions and the
//           instruction classifier used by the LCD transmitter and receiver.
// Rev     : 1.0  initial release
// ============================================================================
package lcd_pkg;

    // Instruction class, selected by the highest set bit of an rs=0 byte
    typedef enum logic [3:0] {
        CMD_NONE    = 4'd0,
        CMD_CLEAR   = 4'd1,
        CMD_HOME    = 4'd2,
        CMD_ENTRY   = 4'd3,
        CMD_DISPLAY = 4'd4,
        CMD_SHIFT   = 4'd5,
        CMD_FUNC    = 4'd6,
        CMD_CGRAM   = 4'd7,
        CMD_DDRAM   = 4'd8
    } cmd_e;

    // Nibble phase of the 4-bit interface
    typedef enum logic [0:0] {
        PHASE_HI = 1'b0,
        PHASE_LO = 1'b1
    } phase_e;

    // Bit positions inside instruction bytes
    localparam int ENTRY_ID = 1;   // entry mode: increment/decrement
    localparam int DISP_D   = 2;   // display control: display on
    localparam int FUNC_DL  = 4;   // function set: 8-bit data length

    // Decode an instruction byte into its class, highest set bit wins
    function automatic cmd_e classify(input logic [7:0] b);
        cmd_e c;
        if (b[7])      c = CMD_DDRAM;
        else if (b[6]) c = CMD_CGRAM;
        else if (b[5]) c = CMD_FUNC;
        else if (b[4]) c = CMD_SHIFT;
        else if (b[3]) c = CMD_DISPLAY;
        else if (b[2]) c = CMD_ENTRY;
        else if (b[1]) c = CMD_HOME;
        else if (b[0]) c = CMD_CLEAR;
        else           c = CMD_NONE;
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_rx_sync.sv
`default_nettype none
// ============================================================================
// Module : lcd_rx_sync
// Desc   : Three-stage synchroniser for the asynchronous LCD bus. Flags the
//          falling edge of en and presents rs/data as seen while en was high.
// Rev    : 1.0  initial release
// ============================================================================
module lcd_rx_sync (
    input  logic       clk,
    input  logic       reset,
    input  logic       lcd_en,
    input  logic       lcd_rs,
    input  logic [3:0] lcd_data,
    output logic       fall,
    output logic       rs_s,
    output logic [3:0] nib_s
);

    logic       en_s1, en_s2, en_s3;
    logic [4:0] pay_s1, pay_s2, pay_s3;   // {rs, data}

    // Shift the bus through three flop stages; en resets low
    always_ff @(posedge clk) begin
        if (reset) begin
            en_s1  <= 1'b0;
            en_s2  <= 1'b0;
            en_s3  <= 1'b0;
            pay_s1 <= '0;
            pay_s2 <= '0;
            pay_s3 <= '0;
        end else begin
            en_s1  <= lcd_en;
            en_s2  <= en_s1;
            en_s3  <= en_s2;
            pay_s1 <= {lcd_rs, lcd_data};
            pay_s2 <= pay_s1;
            pay_s3 <= pay_s2;
        end
    end

    // s3 still holds the last en-high sample when s2 first shows en low,
    // so its payload is the value that was valid during the strobe
    assign fall  = en_s3 & ~en_s2;
    assign rs_s  = pay_s3[4];
    assign nib_s = pay_s3[3:0];

endmodule
`default_nettype wire

// File: rtl/lcd_rx.sv
`default_nettype none
// ============================================================================
// Module : lcd_rx
// Desc   : HD44780-compatible write-only receiver. Rebuilds bytes from the
//          4/8-bit LCD bus, decodes instructions, tracks the DDRAM address
//          counter and display state, and reports character writes.
// Rev    : 1.0  initial release
// ============================================================================
module lcd_rx
    import lcd_pkg::*;
#(
    parameter int unsigned BUSY_CYCLES  = 1,
    parameter int unsigned CLEAR_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       lcd_en,
    input  logic       lcd_rs,
    input  logic [3:0] lcd_data,
    output logic       wr_valid,
    output logic [6:0] wr_addr,
    output logic [7:0] wr_char,
    output logic       clear_pulse,
    output logic [6:0] cursor_addr,
    output logic       display_on,
    output logic       mode_4bit,
    output logic       busy,
    output logic       overrun
);

    localparam logic [CNT_W-1:0] BUSY_LOAD  = CNT_W'(BUSY_CYCLES);
    localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    // Synchronised bus
    logic       fall;
    logic       rs_s;
    logic [3:0] nib_s;

    // Internal state and next-state values
    phase_e           phase,  phase_nx;
    logic [3:0]       hi_nib, hi_nib_nx;
    logic             inc,    inc_nx;
    logic             cg_sel, cg_sel_nx;
    logic [CNT_W-1:0] busy_cnt, busy_cnt_nx;

    logic       wr_valid_nx;
    logic [6:0] wr_addr_nx;
    logic [7:0] wr_char_nx;
    logic       clear_pulse_nx;
    logic [6:0] cursor_addr_nx;
    logic       display_on_nx;
    logic       mode_4bit_nx;
    logic       overrun_nx;

    // Byte assembly
    logic       byte_done;
    logic [7:0] byte_val;
    cmd_e       cmd;

    lcd_rx_sync u_sync (
        .clk      (clk),
        .reset    (reset),
        .lcd_en   (lcd_en),
        .lcd_rs   (lcd_rs),
        .lcd_data (lcd_data),
        .fall     (fall),
        .rs_s     (rs_s),
        .nib_s    (nib_s)
    );

    // A strobe completes a byte in 8-bit mode, or on the low nibble in 4-bit mode
    assign byte_done = fall & (~mode_4bit | (phase == PHASE_LO));
    assign byte_val  = mode_4bit ? {hi_nib, nib_s} : {nib_s, 4'h0};
    assign cmd       = classify(byte_val);

    // Next-state: nibble phase, instruction decode, data writes and busy timer
    always_comb begin
        phase_nx       = phase;
        hi_nib_nx      = hi_nib;
        inc_nx         = inc;
        cg_sel_nx      = cg_sel;
        cursor_addr_nx = cursor_addr;
        display_on_nx  = display_on;
        mode_4bit_nx   = mode_4bit;
        overrun_nx     = overrun;
        wr_valid_nx    = 1'b0;
        wr_addr_nx     = wr_addr;
        wr_char_nx     = wr_char;
        clear_pulse_nx = 1'b0;
        busy_cnt_nx    = (busy_cnt != '0) ? (busy_cnt - CNT_ONE) : '0;

        // Any strobe arriving while busy is flagged but still processed
        if (fall && busy) begin
            overrun_nx = 1'b1;
        end

        // First half of a 4-bit transfer: hold the high nibble only
        if (fall && mode_4bit && (phase == PHASE_HI)) begin
            hi_nib_nx = nib_s;
            phase_nx  = PHASE_LO;
        end

        if (byte_done) begin
            phase_nx    = PHASE_HI;
            busy_cnt_nx = BUSY_LOAD;
            if (rs_s) begin
                // Data byte: CGRAM writes are swallowed but still move the cursor
                if (!cg_sel) begin
                    wr_valid_nx = 1'b1;
                    wr_addr_nx  = cursor_addr;
                    wr_char_nx  = byte_val;
                end
                cursor_addr_nx = inc ? (cursor_addr + 7'd1) : (cursor_addr - 7'd1);
            end else begin
                case (cmd)
                    CMD_CLEAR: begin
                        cursor_addr_nx = '0;
                        inc_nx         = 1'b1;
                        clear_pulse_nx = 1'b1;
                        busy_cnt_nx    = CLEAR_LOAD;
                    end
                    CMD_HOME: begin
                        cursor_addr_nx = '0;
                        busy_cnt_nx    = CLEAR_LOAD;
                    end
                    CMD_ENTRY: begin
                        inc_nx = byte_val[ENTRY_ID];
                    end
                    CMD_DISPLAY: begin
                        display_on_nx = byte_val[DISP_D];
                    end
                    CMD_FUNC: begin
                        // Phase is already back at HI, so a width change
                        // always starts cleanly on a high nibble
                        mode_4bit_nx = ~byte_val[FUNC_DL];
                    end
                    CMD_CGRAM: begin
                        cg_sel_nx = 1'b1;
                    end
                    CMD_DDRAM: begin
                        cursor_addr_nx = byte_val[6:0];
                        cg_sel_nx      = 1'b0;
                    end
                    default: begin
                        // shift commands and null bytes only occupy the bus
                    end
                endcase
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            phase       <= PHASE_HI;
            hi_nib      <= '0;
            inc         <= 1'b1;
            cg_sel      <= 1'b0;
            busy_cnt    <= '0;
            wr_valid    <= 1'b0;
            wr_addr     <= '0;
            wr_char     <= '0;
            clear_pulse <= 1'b0;
            cursor_addr <= '0;
            display_on  <= 1'b0;
            mode_4bit   <= 1'b0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            phase       <= phase_nx;
            hi_nib      <= hi_nib_nx;
            inc         <= inc_nx;
            cg_sel      <= cg_sel_nx;
            busy_cnt    <= busy_cnt_nx;
            wr_valid    <= wr_valid_nx;
            wr_addr     <= wr_addr_nx;
            wr_char     <= wr_char_nx;
            clear_pulse <= clear_pulse_nx;
            cursor_addr <= cursor_addr_nx;
            display_on  <= display_on_nx;
            mode_4bit   <= mode_4bit_nx;
            busy        <= (busy_cnt_nx != '0);
            overrun     <= overrun_nx;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lcd_rx.sv
`default_nettype none
// ============================================================================
// Module : tb_lcd_rx
// Desc   : Self-checking bench for lcd_rx with a byte-level LCD model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_lcd_rx;

    localparam int BUSY_C  = 1;
    localparam int CLEAR_C = 2;
    localparam int HI_T    = 2;
    localparam int LO_T    = 4;

    typedef struct packed {
        logic [31:0] cyc;
        logic [6:0]  addr;
        logic [7:0]  ch;
    } wr_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       lcd_en;
    logic       lcd_rs;
    logic [3:0] lcd_data;
    logic       wr_valid;
    logic [6:0] wr_addr;
    logic [7:0] wr_char;
    logic       clear_pulse;
    logic [6:0] cursor_addr;
    logic       display_on;
    logic       mode_4bit;
    logic       busy;
    logic       overrun;

    int  cyc = 0;
    int  clr_seen = 0;
    int  n_cmp = 0;
    int  n_fail = 0;
    wr_t obs_q[$];
    wr_t exp_q[$];
    int  obs_rd = 0;
    int  exp_rd = 0;

    // Reference model state (byte-level view of the display controller)
    bit         m4;
    bit         m_phase_lo;
    logic [3:0] m_hi;
    logic [6:0] m_cur;
    bit         m_inc, m_cg, m_don, m_ovr;
    int         m_busy_until, m_last_dec;
    int         m_clears = 0;

    lcd_rx #(
        .BUSY_CYCLES  (BUSY_C),
        .CLEAR_CYCLES (CLEAR_C),
        .CNT_W        (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .lcd_en      (lcd_en),
        .lcd_rs      (lcd_rs),
        .lcd_data    (lcd_data),
        .wr_valid    (wr_valid),
        .wr_addr     (wr_addr),
        .wr_char     (wr_char),
        .clear_pulse (clear_pulse),
        .cursor_addr (cursor_addr),
        .display_on  (display_on),
        .mode_4bit   (mode_4bit),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every write pulse and clear pulse, with the edge it followed
    always @(negedge clk) begin
        if (wr_valid) obs_q.push_back(wr_t'{32'(cyc), wr_addr, wr_char});
        if (clear_pulse) clr_seen = clr_seen + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m4 = 0; m_phase_lo = 0; m_hi = '0; m_cur = '0;
        m_inc = 1; m_cg = 0; m_don = 0; m_ovr = 0;
        m_busy_until = -100; m_last_dec = -100;
    endtask

    // Apply one strobe to the model; f is the clock edge that acts on it
    task automatic model_strobe(input logic rs, input logic [3:0] nib, input int f);
        logic [7:0] b;
        int dur;
        if (f <= m_busy_until) m_ovr = 1;
        if (m4 && !m_phase_lo) begin
            m_hi = nib;
            m_phase_lo = 1;
            return;
        end
        b = m4 ? {m_hi, nib} : {nib, 4'h0};
        m_phase_lo = 0;
        dur = BUSY_C;
        if (rs) begin
            if (!m_cg) exp_q.push_back(wr_t'{32'(f), m_cur, b});
            m_cur = m_inc ? 7'((int'(m_cur) + 1) % 128) : 7'((int'(m_cur) + 127) % 128);
        end else if (b >= 8'h80) begin
            m_cur = b[6:0]; m_cg = 0;
        end else if (b >= 8'h40) begin
            m_cg = 1;
        end else if (b >= 8'h20) begin
            m4 = (b[4] == 1'b0);
        end else if (b >= 8'h10) begin
            dur = BUSY_C;
        end else if (b >= 8'h08) begin
            m_don = b[2];
        end else if (b >= 8'h04) begin
            m_inc = b[1];
        end else if (b >= 8'h02) begin
            m_cur = '0; dur = CLEAR_C;
        end else if (b == 8'h01) begin
            m_cur = '0; m_inc = 1; m_clears++; dur = CLEAR_C;
        end
        m_last_dec = f;
        m_busy_until = f + dur;
    endtask

    // Drive one en strobe: high for hi periods, then low for lo periods
    task automatic strobe(input logic rs, input logic [3:0] nib, input int hi, input int lo);
        @(negedge clk);
        lcd_rs = rs; lcd_data = nib; lcd_en = 1'b1;
        repeat (hi - 1) @(negedge clk);
        @(negedge clk);
        lcd_en = 1'b0;
        model_strobe(rs, nib, cyc + 3);
        repeat (lo - 1) @(negedge clk);
    endtask

    task automatic send_byte(input logic rs, input logic [7:0] b, input int hi, input int lo);
        if (m4) begin
            strobe(rs, b[7:4], hi, lo);
            strobe(rs, b[3:0], hi, lo);
        end else begin
            strobe(rs, b[7:4], hi, lo);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic settle();
        repeat (6) @(negedge clk);
    endtask

    task automatic init_seq();
        strobe(0, 4'h3, HI_T, LO_T);
        strobe(0, 4'h3, HI_T, LO_T);
        strobe(0, 4'h3, HI_T, LO_T);
        strobe(0, 4'h2, HI_T, LO_T);
        settle();
    endtask

    task automatic test_reset();
        lcd_en = 0; lcd_rs = 0; lcd_data = '0; reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        n_cmp++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_wr_valid: actual %b required 0", wr_valid); end
        n_cmp++; if (wr_addr !== 7'h00) begin n_fail++; $display("FAIL rst_wr_addr: actual %h required 00", wr_addr); end
        n_cmp++; if (wr_char !== 8'h00) begin n_fail++; $display("FAIL rst_wr_char: actual %h required 00", wr_char); end
        n_cmp++; if (clear_pulse !== 1'b0) begin n_fail++; $display("FAIL rst_clear: actual %b required 0", clear_pulse); end
        n_cmp++; if (cursor_addr !== 7'h00) begin n_fail++; $display("FAIL rst_cursor: actual %h required 00", cursor_addr); end
        n_cmp++; if (display_on !== 1'b0) begin n_fail++; $display("FAIL rst_display: actual %b required 0", display_on); end
        n_cmp++; if (mode_4bit !== 1'b0) begin n_fail++; $display("FAIL rst_mode: actual %b required 0", mode_4bit); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: actual %b required 0", busy); end
        n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL rst_overrun: actual %b required 0", overrun); end
    endtask

    task automatic test_init();
        init_seq();
        n_cmp++; if (mode_4bit !== 1'b1) begin n_fail++; $display("FAIL init_mode: actual %b required 1", mode_4bit); end
        n_cmp++; if (obs_q.size() != obs_rd) begin n_fail++; $display("FAIL init_no_wr: actual %0d writes required 0", obs_q.size() - obs_rd); obs_rd = obs_q.size(); end
    endtask

    task automatic test_basic();
        send_byte(0, 8'h0C, HI_T, LO_T);
        send_byte(0, 8'h01, HI_T, LO_T);
        send_byte(0, 8'h06, HI_T, LO_T);
        send_byte(0, 8'h80, HI_T, LO_T);
        send_byte(1, 8'h48, HI_T, LO_T);
        send_byte(1, 8'h69, HI_T, LO_T);
        settle();
        while (exp_rd < exp_q.size()) begin
            n_cmp++;
            if (obs_rd >= obs_q.size()) begin
                n_fail++; $display("FAIL basic_wr: actual none required addr=%h char=%h", exp_q[exp_rd].addr, exp_q[exp_rd].ch);
            end else begin
                if (obs_q[obs_rd] !== exp_q[exp_rd]) begin n_fail++; $display("FAIL basic_wr: actual cyc=%0d addr=%h char=%h required cyc=%0d addr=%h char=%h", obs_q[obs_rd].cyc, obs_q[obs_rd].addr, obs_q[obs_rd].ch, exp_q[exp_rd].cyc, exp_q[exp_rd].addr, exp_q[exp_rd].ch); end
                obs_rd++;
            end
            exp_rd++;
        end
        n_cmp++; if (obs_rd != obs_q.size()) begin n_fail++; $display("FAIL basic_extra_wr: actual %0d required %0d", obs_q.size(), obs_rd); obs_rd = obs_q.size(); end
        n_cmp++; if (display_on !== 1'b1) begin n_fail++; $display("FAIL basic_display: actual %b required 1", display_on); end
        n_cmp++; if (clr_seen != 1) begin n_fail++; $display("FAIL basic_clear_cnt: actual %0d required 1", clr_seen); end
        n_cmp++; if (cursor_addr !== 7'd2) begin n_fail++; $display("FAIL basic_cursor: actual %0d required 2", cursor_addr); end
    endtask

    task automatic test_wrap();
        send_byte(0, 8'hFF, HI_T, LO_T);
        send_byte(0, 8'h06, HI_T, LO_T);
        send_byte(1, 8'h41, HI_T, LO_T);
        settle();
        n_cmp++; if (cursor_addr !== 7'd0) begin n_fail++; $display("FAIL wrap_up_cursor: actual %0d required 0", cursor_addr); end
        send_byte(0, 8'h04, HI_T, LO_T);
        send_byte(1, 8'h42, HI_T, LO_T);
        settle();
        n_cmp++; if (cursor_addr !== 7'd127) begin n_fail++; $display("FAIL wrap_dn_cursor: actual %0d required 127", cursor_addr); end
        while (exp_rd < exp_q.size()) begin
            n_cmp++;
            if (obs_rd >= obs_q.size()) begin
                n_fail++; $display("FAIL wrap_wr: actual none required addr=%h char=%h", exp_q[exp_rd].addr, exp_q[exp_rd].ch);
            end else begin
                if (obs_q[obs_rd] !== exp_q[exp_rd]) begin n_fail++; $display("FAIL wrap_wr: actual cyc=%0d addr=%h char=%h required cyc=%0d addr=%h char=%h", obs_q[obs_rd].cyc, obs_q[obs_rd].addr, obs_q[obs_rd].ch, exp_q[exp_rd].cyc, exp_q[exp_rd].addr, exp_q[exp_rd].ch); end
                obs_rd++;
            end
            exp_rd++;
        end
        n_cmp++; if (obs_rd != obs_q.size()) begin n_fail++; $display("FAIL wrap_extra_wr: actual %0d required %0d", obs_q.size(), obs_rd); obs_rd = obs_q.size(); end
    endtask

    task automatic test_reset_mid();
        strobe(0, 4'h4, HI_T, LO_T);
        settle();
        do_reset();
        strobe(0, 4'h8, HI_T, LO_T);
        strobe(1, 4'h4, HI_T, LO_T);
        settle();
        n_cmp++; if (mode_4bit !== 1'b0) begin n_fail++; $display("FAIL midrst_mode: actual %b required 0", mode_4bit); end
        n_cmp++; if (cursor_addr !== 7'd1) begin n_fail++; $display("FAIL midrst_cursor: actual %0d required 1", cursor_addr); end
        while (exp_rd < exp_q.size()) begin
            n_cmp++;
            if (obs_rd >= obs_q.size()) begin
                n_fail++; $display("FAIL midrst_wr: actual none required addr=%h char=%h", exp_q[exp_rd].addr, exp_q[exp_rd].ch);
            end else begin
                if (obs_q[obs_rd] !== exp_q[exp_rd]) begin n_fail++; $display("FAIL midrst_wr: actual addr=%h char=%h required addr=%h char=%h", obs_q[obs_rd].addr, obs_q[obs_rd].ch, exp_q[exp_rd].addr, exp_q[exp_rd].ch); end
                obs_rd++;
            end
            exp_rd++;
        end
        n_cmp++; if (obs_rd != obs_q.size()) begin n_fail++; $display("FAIL midrst_extra_wr: actual %0d required %0d", obs_q.size(), obs_rd); obs_rd = obs_q.size(); end
    endtask

    task automatic test_busy();
        bit eb;
        init_seq();
        // Clear, then watch the busy flag edge by edge
        strobe(0, 4'h0, HI_T, LO_T);
        strobe(0, 4'h1, HI_T, 2);
        for (int k = 0; k < 10 && cyc < m_last_dec; k++) @(negedge clk);
        n_cmp++; if (cyc != m_last_dec) begin n_fail++; $display("FAIL busy_wait: actual cyc %0d required %0d", cyc, m_last_dec); end
        for (int i = 0; i < 3; i++) begin
            eb = (cyc >= m_last_dec) && (cyc < m_busy_until);
            n_cmp++; if (busy !== eb) begin n_fail++; $display("FAIL busy_flag%0d: actual %b required %b", i, busy, eb); end
            @(negedge clk);
        end
        n_cmp++; if (overrun !== m_ovr) begin n_fail++; $display("FAIL busy_no_ovr: actual %b required %b", overrun, m_ovr); end
        // Clear followed immediately by another strobe
        strobe(0, 4'h0, 1, 1);
        strobe(0, 4'h1, 1, 1);
        strobe(0, 4'h0, 1, 1);
        strobe(0, 4'h6, HI_T, LO_T);
        settle();
        n_cmp++; if (overrun !== 1'b1 || !m_ovr) begin n_fail++; $display("FAIL busy_ovr_set: actual %b required 1", overrun); end
        send_byte(0, 8'h0C, HI_T, LO_T);
        settle();
        n_cmp++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL busy_ovr_sticky: actual %b required 1", overrun); end
        n_cmp++; if (clr_seen != m_clears) begin n_fail++; $display("FAIL busy_clear_cnt: actual %0d required %0d", clr_seen, m_clears); end
        do_reset();
        @(negedge clk);
        n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL busy_ovr_rst: actual %b required 0", overrun); end
    endtask

    task automatic test_cgram();
        init_seq();
        send_byte(0, 8'h40, HI_T, LO_T);
        send_byte(1, 8'h55, HI_T, LO_T);
        settle();
        n_cmp++; if (cursor_addr !== 7'd1) begin n_fail++; $display("FAIL cg_cursor: actual %0d required 1", cursor_addr); end
        n_cmp++; if (obs_q.size() != obs_rd) begin n_fail++; $display("FAIL cg_no_wr: actual %0d writes required 0", obs_q.size() - obs_rd); obs_rd = obs_q.size(); end
        send_byte(0, 8'h85, HI_T, LO_T);
        send_byte(1, 8'h55, HI_T, LO_T);
        settle();
        n_cmp++; if (cursor_addr !== 7'd6) begin n_fail++; $display("FAIL cg_dd_cursor: actual %0d required 6", cursor_addr); end
        while (exp_rd < exp_q.size()) begin
            n_cmp++;
            if (obs_rd >= obs_q.size()) begin
                n_fail++; $display("FAIL cg_wr: actual none required addr=%h char=%h", exp_q[exp_rd].addr, exp_q[exp_rd].ch);
            end else begin
                if (obs_q[obs_rd] !== exp_q[exp_rd]) begin n_fail++; $display("FAIL cg_wr: actual addr=%h char=%h required addr=%h char=%h", obs_q[obs_rd].addr, obs_q[obs_rd].ch, exp_q[exp_rd].addr, exp_q[exp_rd].ch); end
                obs_rd++;
            end
            exp_rd++;
        end
        n_cmp++; if (obs_rd != obs_q.size()) begin n_fail++; $display("FAIL cg_extra_wr: actual %0d required %0d", obs_q.size(), obs_rd); obs_rd = obs_q.size(); end
    endtask

    task automatic test_random();
        logic       rs;
        logic [7:0] b;
        do_reset();
        init_seq();
        for (int i = 0; i < 60; i++) begin
            rs = 1'($urandom_range(0, 1));
            b  = 8'($urandom);
            send_byte(rs, b, $urandom_range(1, 3), $urandom_range(1, 4));
        end
        settle();
        while (exp_rd < exp_q.size()) begin
            n_cmp++;
            if (obs_rd >= obs_q.size()) begin
                n_fail++; $display("FAIL rand_wr: actual none required addr=%h char=%h", exp_q[exp_rd].addr, exp_q[exp_rd].ch);
            end else begin
                if (obs_q[obs_rd] !== exp_q[exp_rd]) begin n_fail++; $display("FAIL rand_wr: actual cyc=%0d addr=%h char=%h required cyc=%0d addr=%h char=%h", obs_q[obs_rd].cyc, obs_q[obs_rd].addr, obs_q[obs_rd].ch, exp_q[exp_rd].cyc, exp_q[exp_rd].addr, exp_q[exp_rd].ch); end
                obs_rd++;
            end
            exp_rd++;
        end
        n_cmp++; if (obs_rd != obs_q.size()) begin n_fail++; $display("FAIL rand_extra_wr: actual %0d required %0d", obs_q.size(), obs_rd); obs_rd = obs_q.size(); end
        n_cmp++; if (cursor_addr !== m_cur) begin n_fail++; $display("FAIL rand_cursor: actual %0d required %0d", cursor_addr, m_cur); end
        n_cmp++; if (display_on !== m_don) begin n_fail++; $display("FAIL rand_display: actual %b required %b", display_on, m_don); end
        n_cmp++; if (mode_4bit !== m4) begin n_fail++; $display("FAIL rand_mode: actual %b required %b", mode_4bit, m4); end
        n_cmp++; if (overrun !== m_ovr) begin n_fail++; $display("FAIL rand_overrun: actual %b required %b", overrun, m_ovr); end
        n_cmp++; if (clr_seen != m_clears) begin n_fail++; $display("FAIL rand_clear_cnt: actual %0d required %0d", clr_seen, m_clears); end
    endtask

    initial begin
        test_reset();
        test_init();
        test_basic();
        test_wrap();
        test_reset_mid();
        test_busy();
        test_cgram();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
